// File: rtl/apb_cmd_master.sv
// APB requester: takes one command on a valid/ready port, runs SETUP/ACCESS, returns a one-cycle response.
// Optional ACCESS wait-state abort is enabled by defining APB_TIMEOUT_EN.
module apb_cmd_master #(
    parameter int ADDR_W         = 5,
    parameter int DATA_W         = 8,
    parameter int TIMEOUT_CYCLES = 16
) (
    input  logic              pclk,
    input  logic              preset,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic              cmd_write,
    input  logic [ADDR_W-1:0] cmd_addr,
    input  logic [DATA_W-1:0] cmd_wdata,
    output logic              rsp_valid,
    output logic [DATA_W-1:0] rsp_rdata,
    output logic              rsp_err,
    output logic              psel,
    output logic              penable,
    output logic              pwrite,
    output logic [ADDR_W-1:0] paddr,
    output logic [DATA_W-1:0] pwdata,
    input  logic              pready,
    input  logic [DATA_W-1:0] prdata,
    output logic [1:0]        dbg_state
);

    // Handshake: a command transfers on a posedge where cmd_valid && cmd_ready;
    // cmd_ready depends only on the state, never on cmd_valid.
    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SETUP  = 2'd1,
        ST_ACCESS = 2'd2
    } state_t;

    state_t              r_state;
    logic                r_psel;
    logic                r_penable;
    logic                r_pwrite;
    logic [ADDR_W-1:0]   r_paddr;
    logic [DATA_W-1:0]   r_pwdata;
    logic                r_rsp_valid;
    logic [DATA_W-1:0]   r_rsp_rdata;

`ifdef APB_TIMEOUT_EN
    localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
    logic [CNT_W-1:0]    r_wait_cnt;
    logic                r_rsp_err;
`else
    logic                w_unused_timeout_cfg;
    assign w_unused_timeout_cfg = (TIMEOUT_CYCLES == 0);
`endif

    always_ff @(posedge pclk) begin
        if (preset) begin
            r_state     <= ST_IDLE;
            r_psel      <= 1'b0;
            r_penable   <= 1'b0;
            r_pwrite    <= 1'b0;
            r_paddr     <= '0;
            r_pwdata    <= '0;
            r_rsp_valid <= 1'b0;
            r_rsp_rdata <= '0;
`ifdef APB_TIMEOUT_EN
            r_wait_cnt  <= '0;
            r_rsp_err   <= 1'b0;
`endif
        end else begin
            r_rsp_valid <= 1'b0;
`ifdef APB_TIMEOUT_EN
            r_rsp_err   <= 1'b0;
`endif
            case (r_state)
                ST_IDLE: begin
                    if (cmd_valid) begin
                        r_pwrite <= cmd_write;
                        r_paddr  <= cmd_addr;
                        r_pwdata <= cmd_wdata;
                        r_psel   <= 1'b1;
                        r_state  <= ST_SETUP;
                    end
                end
                ST_SETUP: begin
                    r_penable  <= 1'b1;
                    r_state    <= ST_ACCESS;
`ifdef APB_TIMEOUT_EN
                    r_wait_cnt <= '0;
`endif
                end
                ST_ACCESS: begin
                    // pready on the final wait cycle still completes normally.
                    if (pready) begin
                        r_psel      <= 1'b0;
                        r_penable   <= 1'b0;
                        r_rsp_valid <= 1'b1;
                        r_rsp_rdata <= r_pwrite ? '0 : prdata;
                        r_state     <= ST_IDLE;
                    end
`ifdef APB_TIMEOUT_EN
                    else if (r_wait_cnt == CNT_W'(TIMEOUT_CYCLES - 1)) begin
                        r_psel      <= 1'b0;
                        r_penable   <= 1'b0;
                        r_rsp_valid <= 1'b1;
                        r_rsp_err   <= 1'b1;
                        r_rsp_rdata <= '0;
                        r_state     <= ST_IDLE;
                    end else begin
                        r_wait_cnt  <= r_wait_cnt + CNT_W'(1);
                    end
`endif
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    assign cmd_ready = (r_state == ST_IDLE);
    assign psel      = r_psel;
    assign penable   = r_penable;
    assign pwrite    = r_pwrite;
    assign paddr     = r_paddr;
    assign pwdata    = r_pwdata;
    assign rsp_valid = r_rsp_valid;
    assign rsp_rdata = r_rsp_rdata;
    assign dbg_state = r_state;

`ifdef APB_TIMEOUT_EN
    assign rsp_err   = r_rsp_err;
`else
    assign rsp_err   = 1'b0;
`endif

endmodule

// File: tb/tb_apb_cmd_master.sv
// Bench for apb_cmd_master: transfer-level reference model, per-cycle compare, response scoreboard.
// Build with APB_TIMEOUT_EN defined to include the wait-state abort scenario.
module tb_apb_cmd_master;

  localparam int AW = 5;
  localparam int DW = 8;
  localparam int TO = 4;
`ifdef APB_TIMEOUT_EN
  localparam bit TO_EN = 1'b1;
`else
  localparam bit TO_EN = 1'b0;
`endif

  // clock / reset
  logic pclk = 1'b0;
  always #5 pclk = ~pclk;

  logic          preset = 1'b1;
  logic          cmd_valid = 1'b0;
  logic          cmd_ready;
  logic          cmd_write = 1'b0;
  logic [AW-1:0] cmd_addr = '0;
  logic [DW-1:0] cmd_wdata = '0;
  logic          rsp_valid;
  logic [DW-1:0] rsp_rdata;
  logic          rsp_err;
  logic          psel;
  logic          penable;
  logic          pwrite;
  logic [AW-1:0] paddr;
  logic [DW-1:0] pwdata;
  logic          pready = 1'b0;
  logic [DW-1:0] prdata = '0;
  logic [1:0]    dbg_state;

  apb_cmd_master #(.ADDR_W(AW), .DATA_W(DW), .TIMEOUT_CYCLES(TO)) dut (
    .pclk(pclk), .preset(preset),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
    .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata),
    .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
    .psel(psel), .penable(penable), .pwrite(pwrite), .paddr(paddr), .pwdata(pwdata),
    .pready(pready), .prdata(prdata), .dbg_state(dbg_state)
  );

  int n_checks = 0;
  int n_errors = 0;
  bit chk_en = 1'b0;
  bit sb_en = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [DW-1:0] init_val(input int i);
    return DW'(i * 37 + 11);
  endfunction

  // Reference model: a transfer is "busy" from acceptance until its response;
  // m_t counts cycles since acceptance (1 = setup, >=2 = access).
  bit            m_busy = 1'b0;
  int            m_t = 0;
  logic          m_pwrite = 1'b0;
  logic [AW-1:0] m_paddr = '0;
  logic [DW-1:0] m_pwdata = '0;
  logic [DW-1:0] m_rdata = '0;
  bit            m_rv = 1'b0;
  bit            m_err = 1'b0;
  logic [DW-1:0] exp_q[$];
  logic [DW-1:0] shadow [0:31];
  logic [DW-1:0] slave_mem [0:31];

  always @(posedge pclk) begin
    if (preset) begin
      m_busy <= 1'b0; m_t <= 0; m_pwrite <= 1'b0; m_paddr <= '0; m_pwdata <= '0;
      m_rdata <= '0; m_rv <= 1'b0; m_err <= 1'b0;
      exp_q.delete();
      for (int i = 0; i < 32; i++) shadow[i] <= init_val(i);
    end else begin
      m_rv <= 1'b0;
      m_err <= 1'b0;
      if (!m_busy) begin
        if (cmd_valid) begin
          m_busy <= 1'b1; m_t <= 1;
          m_pwrite <= cmd_write; m_paddr <= cmd_addr; m_pwdata <= cmd_wdata;
          if (cmd_write) shadow[cmd_addr] <= cmd_wdata;
          if (sb_en) exp_q.push_back(cmd_write ? '0 : shadow[cmd_addr]);
        end
      end else if (m_t >= 2 && pready) begin
        m_busy <= 1'b0; m_rv <= 1'b1; m_rdata <= m_pwrite ? '0 : prdata;
      end else if (m_t >= 2 && TO_EN && (m_t - 1) == TO) begin
        m_busy <= 1'b0; m_rv <= 1'b1; m_err <= 1'b1; m_rdata <= '0;
      end else begin
        m_t <= m_t + 1;
      end
    end
  end

  // Simple memory slave used by the randomized phase.
  always @(posedge pclk) begin
    if (preset) begin
      for (int i = 0; i < 32; i++) slave_mem[i] <= init_val(i);
    end else if (psel && penable && pready && pwrite) begin
      slave_mem[paddr] <= pwdata;
    end
  end

  // scoreboard / per-cycle compare
  always @(negedge pclk) begin
    if (chk_en) begin
      chk("cmd_ready", cmd_ready, !m_busy);
      chk("psel", psel, m_busy);
      chk("penable", penable, m_busy && m_t >= 2);
      chk("pwrite", pwrite, m_pwrite);
      chk("paddr", paddr, m_paddr);
      chk("pwdata", pwdata, m_pwdata);
      chk("rsp_valid", rsp_valid, m_rv);
      chk("rsp_rdata", rsp_rdata, m_rdata);
      chk("rsp_err", rsp_err, m_err);
      if (sb_en && rsp_valid) begin
        if (exp_q.size() == 0) chk("sb_pending", 0, 1);
        else chk("sb_rdata", rsp_rdata, exp_q.pop_front());
      end
    end
  end

  // driver tasks
  task automatic send(input logic w, input logic [AW-1:0] a, input logic [DW-1:0] d);
    cmd_valid = 1'b1; cmd_write = w; cmd_addr = a; cmd_wdata = d;
    @(negedge pclk);
    cmd_valid = 1'b0;
  endtask

  logic [DW-1:0] seq_rd [3];
  int            seq_cyc [3];

  initial begin
    int pulses, cyc, k, zeros;
    bit was_ready;
    logic          t4_w [3];
    logic [AW-1:0] t4_a [3];
    logic [DW-1:0] t4_d [3];
    t4_w[0] = 1'b1; t4_a[0] = 5'd7; t4_d[0] = 8'h3C;
    t4_w[1] = 1'b0; t4_a[1] = 5'd7; t4_d[1] = 8'h00;
    t4_w[2] = 1'b0; t4_a[2] = 5'd2; t4_d[2] = 8'h00;

    // 1: reset
    preset = 1'b1;
    repeat (2) @(posedge pclk);
    @(negedge pclk);
    chk("rst_psel", psel, 0);
    chk("rst_penable", penable, 0);
    chk("rst_pwrite", pwrite, 0);
    chk("rst_paddr", paddr, 0);
    chk("rst_pwdata", pwdata, 0);
    chk("rst_rsp_valid", rsp_valid, 0);
    chk("rst_rsp_rdata", rsp_rdata, 0);
    chk("rst_rsp_err", rsp_err, 0);
    preset = 1'b0;
    chk_en = 1'b1;
    @(negedge pclk);
    chk("rst_cmd_ready", cmd_ready, 1);

    // 2: zero-wait write
    pready = 1'b1;
    send(1'b1, 5'h03, 8'hA5);                 // now in cycle N+1
    chk("wr_setup_psel", psel, 1);
    chk("wr_setup_penable", penable, 0);
    chk("wr_paddr", paddr, 5'h03);
    chk("wr_pwdata", pwdata, 8'hA5);
    chk("wr_pwrite", pwrite, 1);
    chk("wr_setup_ready", cmd_ready, 0);
    @(negedge pclk);                          // N+2
    chk("wr_access_penable", penable, 1);
    chk("wr_access_rsp", rsp_valid, 0);
    @(negedge pclk);                          // N+3
    chk("wr_rsp_valid", rsp_valid, 1);
    chk("wr_rsp_rdata", rsp_rdata, 0);
    chk("wr_rsp_err", rsp_err, 0);
    chk("wr_done_psel", psel, 0);
    chk("wr_done_ready", cmd_ready, 1);
    @(negedge pclk);
    chk("wr_pulse_width", rsp_valid, 0);

    // 3: read with three wait states
    pready = 1'b0;
    send(1'b0, 5'h1F, 8'h77);                 // N+1
    chk("rd_setup_penable", penable, 0);
    for (int i = 2; i <= 5; i++) begin
      @(negedge pclk);                        // N+i
      chk("rd_access_psel", psel, 1);
      chk("rd_access_penable", penable, 1);
      chk("rd_paddr", paddr, 5'h1F);
      chk("rd_pwrite", pwrite, 0);
      chk("rd_no_rsp", rsp_valid, 0);
      if (i == 5) begin pready = 1'b1; prdata = 8'h5C; end
    end
    @(negedge pclk);                          // N+6
    pready = 1'b0;
    chk("rd_rsp_valid", rsp_valid, 1);
    chk("rd_rsp_rdata", rsp_rdata, 8'h5C);
    @(negedge pclk);
    chk("rd_pulse_width", rsp_valid, 0);
    chk("rd_rdata_hold", rsp_rdata, 8'h5C);

    // 4: three commands with cmd_valid held high
    pready = 1'b1; prdata = 8'h3C;
    k = 0; pulses = 0; cyc = 0;
    cmd_valid = 1'b1; cmd_write = t4_w[0]; cmd_addr = t4_a[0]; cmd_wdata = t4_d[0];
    was_ready = cmd_ready;
    while (pulses < 3 && cyc < 40) begin
      @(negedge pclk);
      cyc++;
      if (rsp_valid) begin
        seq_rd[pulses] = rsp_rdata; seq_cyc[pulses] = cyc; pulses++;
      end
      if (was_ready && cmd_valid) begin
        k++;
        if (k < 3) begin cmd_write = t4_w[k]; cmd_addr = t4_a[k]; cmd_wdata = t4_d[k]; end
        else cmd_valid = 1'b0;
      end
      was_ready = cmd_ready;
    end
    chk("b2b_pulses", pulses, 3);
    chk("b2b_cyc0", seq_cyc[0], 3);
    chk("b2b_cyc1", seq_cyc[1], 6);
    chk("b2b_cyc2", seq_cyc[2], 9);
    chk("b2b_rd0", seq_rd[0], 8'h00);
    chk("b2b_rd1", seq_rd[1], 8'h3C);
    chk("b2b_rd2", seq_rd[2], 8'h3C);
    cmd_valid = 1'b0;
    @(negedge pclk);

    // 5: reset during ACCESS
    pready = 1'b0;
    send(1'b1, 5'h09, 8'h99);                 // N+1
    @(negedge pclk);                          // N+2 (access)
    chk("rst_mid_penable", penable, 1);
    preset = 1'b1;
    @(negedge pclk);
    chk("rst_mid_psel", psel, 0);
    chk("rst_mid_penable0", penable, 0);
    chk("rst_mid_rsp", rsp_valid, 0);
    preset = 1'b0;
    @(negedge pclk);
    chk("rst_mid_rsp_after", rsp_valid, 0);
    chk("rst_mid_ready", cmd_ready, 1);

`ifdef APB_TIMEOUT_EN
    // 6: stuck pready aborts after TO access cycles
    pready = 1'b0; prdata = 8'hEE;
    send(1'b0, 5'h04, 8'h00);                 // N+1
    for (int i = 2; i <= TO + 1; i++) begin
      @(negedge pclk);
      chk("to_wait_rsp", rsp_valid, 0);
    end
    @(negedge pclk);                          // N+TO+2
    chk("to_rsp_valid", rsp_valid, 1);
    chk("to_rsp_err", rsp_err, 1);
    chk("to_rsp_rdata", rsp_rdata, 0);
    chk("to_psel", psel, 0);
    pready = 1'b1;
    send(1'b1, 5'h04, 8'h12);
    repeat (2) @(negedge pclk);
    chk("to_next_valid", rsp_valid, 1);
    chk("to_next_err", rsp_err, 0);
`endif

    // randomized phase against the memory slave
    cmd_valid = 1'b0; pready = 1'b0;
    @(negedge pclk);
    sb_en = 1'b1;
    zeros = 0;
    for (int n = 0; n < 600; n++) begin
      cmd_valid = ($urandom_range(0, 3) != 0);
      cmd_write = 1'($urandom_range(0, 1));
      cmd_addr  = AW'($urandom_range(0, 31));
      cmd_wdata = DW'($urandom_range(0, 255));
      if (zeros >= 2) pready = 1'b1;
      else pready = 1'($urandom_range(0, 1));
      zeros = pready ? 0 : zeros + 1;
      prdata = slave_mem[paddr];
      @(negedge pclk);
    end
    cmd_valid = 1'b0; pready = 1'b1;
    prdata = slave_mem[paddr];
    repeat (6) @(negedge pclk);
    chk("sb_drained", exp_q.size(), 0);
    chk("final_idle", cmd_ready, 1);

    chk_en = 1'b0;
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
